// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder: decoder state,
// Gray-code phases of {A,B}, step direction encoding and phase helpers.
package quad_pkg;

  typedef enum logic {
    INIT  = 1'b0,  // no reference phase captured yet
    TRACK = 1'b1   // reference valid, decoding transitions
  } dec_state_e;

  // Quadrature phases {A,B} in forward (up) order.
  localparam logic [1:0] PH_0 = 2'b00;
  localparam logic [1:0] PH_1 = 2'b01;
  localparam logic [1:0] PH_2 = 2'b11;
  localparam logic [1:0] PH_3 = 2'b10;

  // Step direction as presented on updn.
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Phase that follows ph when the encoder moves one step forward.
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] r;
    case (ph)
      PH_0:    r = PH_1;
      PH_1:    r = PH_2;
      PH_2:    r = PH_3;
      default: r = PH_0;
    endcase
    return r;
  endfunction

  // Phase that follows ph when the encoder moves one step backward.
  function automatic logic [1:0] next_dn(input logic [1:0] ph);
    logic [1:0] r;
    case (ph)
      PH_0:    r = PH_3;
      PH_3:    r = PH_2;
      PH_2:    r = PH_1;
      default: r = PH_0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// One encoder channel: 2-flop synchronizer followed by a stability filter
// that accepts a level only after FILT consecutive identical samples.
// valid rises once the first level has been accepted after reset.
module quad_filter #(
  parameter int FILT = 3
) (
  input  logic clk5m,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic valid
);

  localparam logic [3:0] FILT_C = 4'(FILT);

  logic       sync1;
  logic       sync2;
  logic [1:0] primed;  // marks when sync2 holds a real sample, not reset
  logic       cand;    // level currently being qualified
  logic [3:0] run;     // consecutive samples equal to cand, saturates

  // Synchronize, then qualify the level: any change restarts the run,
  // so pulses shorter than FILT samples never reach dout.
  always_ff @(posedge clk5m or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      primed <= 2'b00;
      cand   <= 1'b0;
      run    <= 4'd0;
      dout   <= 1'b0;
      valid  <= 1'b0;
    end else begin
      sync1  <= din;
      sync2  <= sync1;
      primed <= {primed[0], 1'b1};
      if (primed[1]) begin
        if (sync2 != cand) begin
          cand <= sync2;
          run  <= 4'd1;
          if (FILT_C == 4'd1) begin
            dout  <= sync2;
            valid <= 1'b1;
          end
        end else if (run != FILT_C) begin
          run <= run + 4'd1;
          if (run == FILT_C - 4'd1) begin
            dout  <= cand;
            valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filters A/B, decodes Gray transitions into one-cycle
// step pulses with direction, keeps a wrapping position counter with
// synchronous load and a sticky illegal-transition flag.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int FILT  = 3
) (
  input  logic             clk5m,
  input  logic             rst_n,
  input  logic             qa,
  input  logic             qb,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             en,
  output logic             updn,
  output logic [WIDTH-1:0] cnt,
  output logic             err,
  output dec_state_e       state
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic       fa, fb;
  logic       va, vb;
  logic [1:0] phase;

  dec_state_e state_q, state_d;
  logic [1:0] ref_q, ref_d;
  logic       en_d;
  logic       updn_d;
  logic       err_set;

  quad_filter #(.FILT(FILT)) u_filt_a (
    .clk5m (clk5m),
    .rst_n (rst_n),
    .din   (qa),
    .dout  (fa),
    .valid (va)
  );

  quad_filter #(.FILT(FILT)) u_filt_b (
    .clk5m (clk5m),
    .rst_n (rst_n),
    .din   (qb),
    .dout  (fb),
    .valid (vb)
  );

  assign phase = {fa, fb};
  assign state = state_q;

  // Decoder state and reference phase registers.
  always_ff @(posedge clk5m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      ref_q   <= PH_0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
    end
  end

  // Next state, reference update and step/error decode. A double-bit
  // change is flagged and still adopted so tracking resumes from there.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    en_d    = 1'b0;
    updn_d  = updn;
    err_set = 1'b0;
    case (state_q)
      INIT: begin
        if (va && vb) begin
          ref_d   = phase;
          state_d = TRACK;
        end
      end
      TRACK: begin
        if (phase != ref_q) begin
          ref_d = phase;
          if (phase == next_up(ref_q)) begin
            en_d   = 1'b1;
            updn_d = DIR_UP;
          end else if (phase == next_dn(ref_q)) begin
            en_d   = 1'b1;
            updn_d = DIR_DN;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Registered step pulse and direction; updn holds between pulses.
  always_ff @(posedge clk5m or negedge rst_n) begin
    if (!rst_n) begin
      en   <= 1'b0;
      updn <= DIR_UP;
    end else begin
      en   <= en_d;
      updn <= updn_d;
    end
  end

  // Position counter and sticky error; load wins over a step in progress.
  always_ff @(posedge clk5m or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (load) begin
        cnt <= data_in;
      end else if (en) begin
        cnt <= (updn == DIR_DN) ? cnt - ONE : cnt + ONE;
      end
      if (load) begin
        err <= 1'b0;
      end else if (err_set) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder (WIDTH=10, FILT=3): table of phase/load records
// with expected pulse counts, counter and error, then hand-written
// sequences for latency, glitch rejection, load/step collision and reset.
`timescale 1ns/1ps
module tb_quad_decoder;
  import quad_pkg::*;

  localparam int WIDTH = 10;
  localparam int FILT  = 3;

  // ---------------- clock / reset ----------------
  logic             clk5m = 1'b0;
  logic             rst_n;
  logic             qa, qb, load;
  logic [WIDTH-1:0] data_in;
  logic             en, updn, err;
  logic [WIDTH-1:0] cnt;
  dec_state_e       state;

  always #100 clk5m = ~clk5m;  // 5 MHz

  quad_decoder #(.WIDTH(WIDTH), .FILT(FILT)) dut (
    .clk5m   (clk5m),
    .rst_n   (rst_n),
    .qa      (qa),
    .qb      (qb),
    .load    (load),
    .data_in (data_in),
    .en      (en),
    .updn    (updn),
    .cnt     (cnt),
    .err     (err),
    .state   (state)
  );

  // ---------------- scoreboard ----------------
  int total  = 0;
  int passed = 0;
  int n_up   = 0;
  int n_dn   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Pulse monitor, sampled just after the active edge.
  always @(posedge clk5m) begin
    #1;
    if (en) begin
      if (updn) n_dn++;
      else n_up++;
    end
  end

  typedef struct {
    logic             qa;
    logic             qb;
    logic             load;
    logic [WIDTH-1:0] data;
    int               n_up;
    int               n_dn;
    int               cnt;
    int               err;
  } vec_t;

  vec_t tbl[13];
  int   lat;

  // ---------------- driver / test sequence ----------------
  initial begin
    //            qa    qb    load  data  up dn cnt   err
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 10'd0,    0, 0, 0,    0}; // idle after reset
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 10'd0,    1, 0, 1,    0}; // 00->01 up
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 10'd0,    1, 0, 2,    0}; // 01->11 up
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 10'd0,    1, 0, 3,    0}; // 11->10 up
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 10'd0,    1, 0, 4,    0}; // 10->00 up
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 10'd0,    0, 0, 0,    0}; // load 0
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 10'd0,    0, 1, 1023, 0}; // 00->10 down, wrap
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 10'd0,    0, 1, 1022, 0}; // 10->11 down
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 10'd0,    0, 0, 1022, 1}; // 11->00 illegal
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 10'd40,   0, 0, 40,   0}; // load clears err
    tbl[10] = '{1'b0, 1'b1, 1'b0, 10'd0,    1, 0, 41,   0}; // 00->01 up
    tbl[11] = '{1'b0, 1'b1, 1'b1, 10'd1023, 0, 0, 1023, 0}; // load max
    tbl[12] = '{1'b1, 1'b1, 1'b0, 10'd0,    1, 0, 0,    0}; // up wrap to 0

    rst_n = 1'b0; qa = 1'b0; qb = 1'b0; load = 1'b0; data_in = '0;
    repeat (2) @(negedge clk5m);
    check("reset_en",    int'(en),    0);
    check("reset_updn",  int'(updn),  0);
    check("reset_cnt",   int'(cnt),   0);
    check("reset_err",   int'(err),   0);
    check("reset_state", int'(state), int'(INIT));
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk5m);
      n_up = 0; n_dn = 0;
      qa = tbl[i].qa; qb = tbl[i].qb;
      load = tbl[i].load; data_in = tbl[i].data;
      @(negedge clk5m);
      load = 1'b0;
      repeat (11) @(negedge clk5m);
      check($sformatf("vec%0d_up", i),  n_up,       tbl[i].n_up);
      check($sformatf("vec%0d_dn", i),  n_dn,       tbl[i].n_dn);
      check($sformatf("vec%0d_cnt", i), int'(cnt),  tbl[i].cnt);
      check($sformatf("vec%0d_err", i), int'(err),  tbl[i].err);
      if (i == 0) check("vec0_state", int'(state), int'(TRACK));
    end

    // Latency: 11->10 up step; en is seen at the 6th falling edge after
    // the drive, i.e. 2+FILT cycles after the first sampling edge.
    @(negedge clk5m);
    n_up = 0; n_dn = 0;
    qa = 1'b1; qb = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk5m);
      if (en) begin lat = i; break; end
    end
    check("latency", lat - 1, 2 + FILT);
    check("latency_updn", int'(updn), 0);
    repeat (4) @(negedge clk5m);
    check("latency_cnt", int'(cnt), 1);

    // Glitch: qa low for two samples from phase 10 is rejected.
    @(negedge clk5m);
    n_up = 0; n_dn = 0;
    qa = 1'b0;
    repeat (2) @(negedge clk5m);
    qa = 1'b1;
    repeat (12) @(negedge clk5m);
    check("glitch_pulses", n_up + n_dn, 0);
    check("glitch_cnt", int'(cnt), 1);

    // Load arriving in the en cycle of a 10->00 up step wins.
    @(negedge clk5m);
    qa = 1'b0; qb = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk5m);
      if (en) begin lat = i; break; end
    end
    check("collide_en_seen", int'(lat != 0), 1);
    load = 1'b1; data_in = 10'd100;
    @(negedge clk5m);
    load = 1'b0;
    @(negedge clk5m);
    check("collide_cnt", int'(cnt), 100);

    // Illegal 00->11 sets err, then reset during a pending 11->01 step.
    @(negedge clk5m);
    n_up = 0; n_dn = 0;
    qa = 1'b1; qb = 1'b1;
    repeat (10) @(negedge clk5m);
    check("illegal_err", int'(err), 1);
    check("illegal_pulses", n_up + n_dn, 0);
    check("illegal_cnt", int'(cnt), 100);
    qa = 1'b0;
    repeat (3) @(negedge clk5m);
    rst_n = 1'b0;
    #1;
    check("midrst_en",    int'(en),    0);
    check("midrst_updn",  int'(updn),  0);
    check("midrst_cnt",   int'(cnt),   0);
    check("midrst_err",   int'(err),   0);
    check("midrst_state", int'(state), int'(INIT));
    repeat (2) @(negedge clk5m);
    n_up = 0; n_dn = 0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk5m);
    check("postrst_pulses", n_up + n_dn, 0);
    check("postrst_cnt",    int'(cnt),   0);
    check("postrst_state",  int'(state), int'(TRACK));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
